// File: rtl/fpu_defs_div_sqrt_tp.sv
// Shared definitions for the div/sqrt unit.
// Engine state, exponent bias and iteration count helpers.
package fpu_defs_div_sqrt_tp;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  function automatic int bias_f(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int n_it_f(input int p, input int mant_w);
    if (p == 0 || p >= mant_w) return mant_w + 3;
    return p + 3;
  endfunction

endpackage

// File: rtl/div_sqrt_iter_step.sv
// One restoring step shared by divide and sqrt.
// Subtracts the trial value when it fits and reports the result bit.
module div_sqrt_iter_step #(
  parameter int W = 28
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] trial,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  assign q_bit    = rem >= trial;
  assign rem_next = q_bit ? rem - trial : rem;

endmodule

// File: rtl/div_sqrt_iter_engine.sv
// Iterative mantissa divide/sqrt engine, one result bit per cycle.
// Valid/ready on both sides, precision control, tag and kill.
module div_sqrt_iter_engine
  import fpu_defs_div_sqrt_tp::*;
#(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8,
  parameter int PC_W   = 6,
  parameter int TAG_W  = 4
) (
  input  logic              Clk_CI,
  input  logic              Rst_RI,
  input  logic              In_valid_SI,
  output logic              In_ready_SO,
  input  logic              Op_sqrt_SI,
  input  logic [MANT_W:0]   Mant_a_DI,
  input  logic [MANT_W:0]   Mant_b_DI,
  input  logic [EXP_W:0]    Exp_a_DI,
  input  logic [EXP_W:0]    Exp_b_DI,
  input  logic [PC_W-1:0]   Precision_ctl_SI,
  input  logic [TAG_W-1:0]  Tag_DI,
  input  logic              Kill_SI,
  output logic              Out_valid_SO,
  input  logic              Out_ready_SI,
  output logic [MANT_W+2:0] Mant_z_DO,
  output logic              Sticky_SO,
  output logic [EXP_W+1:0]  Exp_z_DO,
  output logic [TAG_W-1:0]  Tag_DO
);

  localparam int MW   = MANT_W + 1;
  localparam int QW   = MANT_W + 3;
  localparam int RW   = MANT_W + 5;
  localparam int XW   = 2 * QW;
  localparam int CW   = $clog2(MANT_W + 4);
  localparam int EW   = EXP_W + 2;
  localparam int BIAS = bias_f(EXP_W);

  state_e state, state_n;

  logic [CW-1:0]    cnt, nit, nit_n, sh;
  logic             op_sqrt;
  logic [MW-1:0]    b;
  logic [RW-1:0]    rem, rem_n;
  logic [XW-1:0]    rad, rad_n, rad_init;
  logic [QW-1:0]    q, q_n;
  logic [QW-1:0]    mant_z;
  logic             sticky;
  logic [EW-1:0]    exp_z;
  logic [TAG_W-1:0] tag;
  logic             accept, last;

  logic [RW-1:0] s_rem, s_trial, s_nrem;
  logic          s_bit;

  logic signed [EW-1:0] ea, eb, e_raw, e_even, e_half, exp_n;

  assign In_ready_SO  = (state == IDLE) && !Kill_SI;
  assign Out_valid_SO = state == DONE;
  assign accept       = In_valid_SI && In_ready_SO;
  assign last         = cnt == nit - 1'b1;
  assign sh           = CW'(QW) - nit;

  // Sqrt pulls two radicand bits per step; divide shifts after it.
  always_comb begin
    s_rem   = op_sqrt ? {rem[RW-3:0], rad[XW-1 -: 2]} : rem;
    s_trial = op_sqrt ? {q, 2'b01} : {{(RW-MW){1'b0}}, b};
    rem_n   = op_sqrt ? s_nrem : {s_nrem[RW-2:0], 1'b0};
    q_n     = {q[QW-2:0], s_bit};
    rad_n   = {rad[XW-3:0], 2'b00};
  end

  div_sqrt_iter_step #(
    .W(RW)
  ) u_step (
    .rem      (s_rem),
    .trial    (s_trial),
    .rem_next (s_nrem),
    .q_bit    (s_bit)
  );

  // Odd unbiased exponent doubles the radicand so the root exponent is exact.
  always_comb begin
    ea     = $signed({1'b0, Exp_a_DI});
    eb     = $signed({1'b0, Exp_b_DI});
    e_raw  = ea - EW'(BIAS);
    e_even = e_raw - {{(EW-1){1'b0}}, e_raw[0]};
    e_half = e_even >>> 1;
    exp_n  = Op_sqrt_SI ? e_half + EW'(BIAS)
                        : ea - eb + EW'(BIAS);
    nit_n  = CW'(n_it_f(int'(Precision_ctl_SI), MANT_W));
    if (!Op_sqrt_SI)
      rad_init = '0;
    else if (e_raw[0])
      rad_init = {Mant_a_DI, {(MANT_W+5){1'b0}}};
    else
      rad_init = {1'b0, Mant_a_DI, {(MANT_W+4){1'b0}}};
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = BUSY;
      BUSY: begin
        if (Kill_SI)   state_n = IDLE;
        else if (last) state_n = DONE;
      end
      DONE: if (Kill_SI || Out_ready_SI) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      cnt     <= '0;
      nit     <= '0;
      op_sqrt <= 1'b0;
      b       <= '0;
      rem     <= '0;
      rad     <= '0;
      q       <= '0;
      mant_z  <= '0;
      sticky  <= 1'b0;
      exp_z   <= '0;
      tag     <= '0;
    end else if (accept) begin
      cnt     <= '0;
      nit     <= nit_n;
      op_sqrt <= Op_sqrt_SI;
      b       <= Mant_b_DI;
      rem     <= Op_sqrt_SI ? '0 : {{(RW-MW){1'b0}}, Mant_a_DI};
      rad     <= rad_init;
      q       <= '0;
      exp_z   <= exp_n;
      tag     <= Tag_DI;
    end else if (state == BUSY) begin
      cnt <= cnt + 1'b1;
      rem <= rem_n;
      rad <= rad_n;
      q   <= q_n;
      if (last) begin
        mant_z <= q_n << sh;
        sticky <= (|rem_n) | (|rad_n);
      end
    end
  end

  assign Mant_z_DO = mant_z;
  assign Sticky_SO = sticky;
  assign Exp_z_DO  = exp_z;
  assign Tag_DO    = tag;

endmodule

// File: tb/tb_div_sqrt_iter_engine.sv
// Directed and randomised bench for div_sqrt_iter_engine (fp32 sizing).
// Expected results come from a scoreboard fed at issue time.
module tb_div_sqrt_iter_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op_sqrt = 1'b0;
  logic [23:0] mant_a = '0;
  logic [23:0] mant_b = '0;
  logic [8:0]  exp_a = '0;
  logic [8:0]  exp_b = '0;
  logic [5:0]  prec = '0;
  logic [3:0]  tag_in = '0;
  logic        kill = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [25:0] mant_z;
  logic        sticky;
  logic [9:0]  exp_z;
  logic [3:0]  tag_out;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [25:0] mant;
    logic        st;
    logic [9:0]  ez;
    logic [3:0]  tag;
    int          nit;
  } exp_t;

  exp_t sb[$];

  div_sqrt_iter_engine dut (
    .Clk_CI           (clk),
    .Rst_RI           (rst),
    .In_valid_SI      (in_valid),
    .In_ready_SO      (in_ready),
    .Op_sqrt_SI       (op_sqrt),
    .Mant_a_DI        (mant_a),
    .Mant_b_DI        (mant_b),
    .Exp_a_DI         (exp_a),
    .Exp_b_DI         (exp_b),
    .Precision_ctl_SI (prec),
    .Tag_DI           (tag_in),
    .Kill_SI          (kill),
    .Out_valid_SO     (out_valid),
    .Out_ready_SI     (out_ready),
    .Mant_z_DO        (mant_z),
    .Sticky_SO        (sticky),
    .Exp_z_DO         (exp_z),
    .Tag_DO           (tag_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] obs,
                       input logic [63:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [25:0] m, input logic st,
                              input logic [9:0] ez, input int nit);
    exp_t e;
    e.mant = m;
    e.st   = st;
    e.ez   = ez;
    e.tag  = '0;
    e.nit  = nit;
    return e;
  endfunction

  function automatic exp_t model(input bit sq, input logic [23:0] a,
                                 input logic [23:0] bb, input logic [8:0] ea,
                                 input logic [8:0] eb, input logic [5:0] p);
    longint x, qf, lo, hi, mid, tr;
    bit     nz;
    int     e, nit;
    exp_t   r;
    nit = (p == 0 || p >= 23) ? 26 : int'(p) + 3;
    if (!sq) begin
      x  = longint'(a) << 25;
      qf = x / longint'(bb);
      nz = (x % longint'(bb)) != 0;
      e  = int'(ea) - int'(eb) + 127;
    end else begin
      e = int'(ea) - 127;
      if ((e & 1) != 0) begin
        x = longint'(a) << 28;
        e = e - 1;
      end else begin
        x = longint'(a) << 27;
      end
      lo = 0;
      hi = longint'(1) << 26;
      while (hi - lo > 1) begin
        mid = (lo + hi) / 2;
        if (mid * mid <= x) lo = mid;
        else hi = mid;
      end
      qf = lo;
      nz = (qf * qf) != x;
      e  = e / 2 + 127;
    end
    tr = (qf >> (26 - nit)) << (26 - nit);
    r = mk(26'(tr), (tr != qf) || nz, 10'(e), nit);
    return r;
  endfunction

  task automatic issue(input bit sq, input logic [23:0] a,
                       input logic [23:0] bb, input logic [8:0] ea,
                       input logic [8:0] eb, input logic [5:0] p,
                       input logic [3:0] tg, input exp_t e);
    int n = 0;
    assert (a[23] && (sq || bb[23]))
      else $error("protocol: non-normalised mantissa");
    op_sqrt  = sq;
    mant_a   = a;
    mant_b   = bb;
    exp_a    = ea;
    exp_b    = eb;
    prec     = p;
    tag_in   = tg;
    in_valid = 1'b1;
    while (!in_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.tag = tg;
    sb.push_back(e);
  endtask

  task automatic collect(input int stall);
    int   n = 0;
    exp_t e;
    out_ready = (stall == 0);
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      check("result_timeout", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    check("latency", 64'(n), 64'(e.nit));
    check("mant_z", 64'(mant_z), 64'(e.mant));
    check("sticky", 64'(sticky), 64'(e.st));
    check("exp_z", 64'(exp_z), 64'(e.ez));
    check("tag", 64'(tag_out), 64'(e.tag));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_ready", 64'(in_ready), 64'd0);
      check("stall_mant", 64'(mant_z), 64'(e.mant));
      check("stall_tag", 64'(tag_out), 64'(e.tag));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_hs_valid", 64'(out_valid), 64'd0);
    check("post_hs_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic watch_silent(input string nm, input int cycles);
    bit seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check(nm, 64'(seen), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_mant", 64'(mant_z), 64'd0);
    check("rst_exp", 64'(exp_z), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    issue(0, 24'hC00000, 24'h800000, 9'd127, 9'd127, 6'd0, 4'h1,
          mk(26'h3000000, 1'b0, 10'd127, 26));
    collect(0);
    issue(0, 24'h800000, 24'hC00000, 9'd127, 9'd127, 6'd0, 4'h2,
          mk(26'h1555555, 1'b1, 10'd127, 26));
    collect(0);
    issue(1, 24'h800000, 24'h000000, 9'd128, 9'd0, 6'd0, 4'h3,
          mk(26'h2D413CC, 1'b1, 10'd127, 26));
    collect(0);
    issue(1, 24'h800000, 24'h000000, 9'd125, 9'd0, 6'd0, 4'h4,
          mk(26'h2000000, 1'b0, 10'd126, 26));
    collect(0);
    issue(0, 24'h800000, 24'hC00000, 9'd127, 9'd127, 6'd7, 4'h5,
          mk(26'h1550000, 1'b1, 10'd127, 10));
    collect(0);

    issue(0, 24'hC00000, 24'h800000, 9'd130, 9'd120, 6'd0, 4'h6,
          mk(26'h3000000, 1'b0, 10'd137, 26));
    collect(5);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] r1, r2;
      logic [23:0] a, bb;
      logic [8:0]  ea, eb;
      logic [5:0]  p;
      bit          sq;
      r1 = $urandom();
      r2 = $urandom();
      a  = {1'b1, r1[22:0]};
      bb = {1'b1, r2[22:0]};
      ea = 9'($urandom_range(100, 150));
      eb = 9'($urandom_range(100, 150));
      p  = (i < 4) ? 6'd0 : 6'($urandom_range(1, 30));
      sq = i[0];
      issue(sq, a, bb, ea, eb, p, 4'(i + 8), model(sq, a, bb, ea, eb, p));
      collect(0);
    end

    issue(0, 24'hC00000, 24'h800000, 9'd127, 9'd127, 6'd0, 4'h7,
          mk(26'h3000000, 1'b0, 10'd127, 26));
    void'(sb.pop_back());
    repeat (9) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    check("kill_valid", 64'(out_valid), 64'd0);
    check("kill_blocks_ready", 64'(in_ready), 64'd0);
    kill = 1'b0;
    #1;
    check("kill_release_ready", 64'(in_ready), 64'd1);
    watch_silent("kill_no_output", 40);

    issue(1, 24'hA00000, 24'h000000, 9'd131, 9'd0, 6'd0, 4'h9,
          mk(26'h0, 1'b0, 10'd0, 26));
    void'(sb.pop_back());
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_mant", 64'(mant_z), 64'd0);
    check("midrst_sticky", 64'(sticky), 64'd0);
    check("midrst_exp", 64'(exp_z), 64'd0);
    check("midrst_tag", 64'(tag_out), 64'd0);
    #5;
    rst = 1'b0;
    watch_silent("midrst_no_output", 40);

    issue(1, 24'h800000, 24'h000000, 9'd128, 9'd0, 6'd0, 4'hA,
          mk(26'h2D413CC, 1'b1, 10'd127, 26));
    collect(0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
